// File: rtl/relu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : relu_pkg
// Description : Shared ReLU datapath defaults and lane type.
// Revision    : 1.0 - initial release
// ============================================================================
package relu_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_LENGTH     = 64;

  typedef logic signed [DEFAULT_DATA_WIDTH-1:0] lane_t;

endpackage : relu_pkg
`default_nettype wire

// File: rtl/relu_lane.sv
`default_nettype none
// ============================================================================
// Module      : relu_lane
// Description : Combinational single-lane ReLU (sign test, mux to zero).
// Revision    : 1.0 - initial release
// ============================================================================
module relu_lane
  import relu_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic w_neg;

  assign w_neg = din[DATA_WIDTH-1];
  assign dout  = w_neg ? '0 : din;

endmodule : relu_lane
`default_nettype wire

// File: rtl/relu.sv
`default_nettype none
// ============================================================================
// Module      : relu
// Description : Vectorised registered ReLU stage, LENGTH independent lanes.
// Revision    : 1.0 - initial release
// ============================================================================
module relu
  import relu_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int LENGTH     = DEFAULT_LENGTH
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                en,
  input  logic [LENGTH-1:0][DATA_WIDTH-1:0]   In,
  output logic [0:LENGTH-1][DATA_WIDTH-1:0]   Out
);

  logic [LENGTH-1:0][DATA_WIDTH-1:0] w_res;
  logic [0:LENGTH-1][DATA_WIDTH-1:0] r_out;

  generate
    for (genvar i = 0; i < LENGTH; i++) begin : g_lane
      relu_lane #(
        .DATA_WIDTH(DATA_WIDTH)
      ) u_lane (
        .din (In[i]),
        .dout(w_res[i])
      );
    end
  endgenerate

  // In and Out run in opposite outer directions, so lanes are copied by index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out <= '0;
    end else if (en) begin
      for (int i = 0; i < LENGTH; i++) begin
        r_out[i] <= w_res[i];
      end
    end
  end

  assign Out = r_out;

endmodule : relu
`default_nettype wire

// File: tb/tb_relu.sv
`default_nettype none
// ============================================================================
// Module      : tb_relu
// Description : Self-checking bench for relu: vector table, directed
//               sequences and randomized traffic against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_relu;

  localparam int DW = 16;
  localparam int LN = 64;

  logic                      clk;
  logic                      reset;
  logic                      en;
  logic [LN-1:0][DW-1:0]     in_v;
  logic [0:LN-1][DW-1:0]     out_v;

  logic [DW-1:0] exp_v [LN];
  int checks;
  int errors;

  typedef struct {
    string            name;
    logic [3:0][15:0] din;
    logic [3:0][15:0] dexp;
  } vec_t;

  vec_t tbl [3];

  relu #(
    .DATA_WIDTH(DW),
    .LENGTH    (LN)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .In   (in_v),
    .Out  (out_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: max(x, 0) on the signed integer value of the lane.
  function automatic logic [DW-1:0] ref_relu(input logic [DW-1:0] x);
    int v;
    v = int'($signed(x));
    return (v > 0) ? x : '0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < LN; i++) exp_v[i] = '0;
  endtask

  // Advance one rising edge, updating the model from inputs held stable before it.
  task automatic tick();
    if (reset) model_clear();
    else if (en) for (int i = 0; i < LN; i++) exp_v[i] = ref_relu(in_v[i]);
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string name);
    int bad;
    bad = -1;
    for (int i = LN - 1; i >= 0; i--) if (out_v[i] !== exp_v[i]) bad = i;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s: lane %0d got %h expected %h", name, bad, out_v[bad], exp_v[bad]);
    end
  endtask

  task automatic check_lane(input string name, input int lane, input logic [DW-1:0] want);
    checks++;
    if (out_v[lane] !== want) begin
      errors++;
      $display("FAIL %s: lane %0d got %h expected %h", name, lane, out_v[lane], want);
    end
  endtask

  function automatic logic [DW-1:0] pick_value();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'h7FFF;
      2: return 16'h8000;
      3: return 16'hFFFF;
      default: return DW'($urandom);
    endcase
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    model_clear();

    tbl[0].name = "mixed_signs";
    tbl[0].din  = {16'hFFFF, 16'h8000, 16'h7FFF, 16'h0000};
    tbl[0].dexp = {16'h0000, 16'h0000, 16'h7FFF, 16'h0000};
    tbl[1].name = "all_positive";
    tbl[1].din  = {16'h7FFF, 16'h00FF, 16'h000A, 16'h0001};
    tbl[1].dexp = {16'h7FFF, 16'h00FF, 16'h000A, 16'h0001};
    tbl[2].name = "all_negative";
    tbl[2].din  = {16'h8000, 16'hFFFF, 16'hFFFE, 16'h8001};
    tbl[2].dexp = {16'h0000, 16'h0000, 16'h0000, 16'h0000};

    // Reset held with en high and arbitrary data: outputs stay zero.
    reset = 1'b1;
    en    = 1'b1;
    for (int i = 0; i < LN; i++) in_v[i] = 16'h1000 + DW'(i);
    #2;
    check_model("reset_initial");
    for (int k = 0; k < 3; k++) tick();
    check_lane("reset_hold_lane0", 0, 16'h0000);
    check_model("reset_hold_all");

    reset = 1'b0;
    in_v  = '0;
    tick();

    // Table vectors on lanes 0..3; remaining lanes carry zero.
    for (int t = 0; t < 3; t++) begin
      in_v = '0;
      for (int l = 0; l < 4; l++) in_v[l] = tbl[t].din[l];
      tick();
      for (int l = 0; l < 4; l++) check_lane(tbl[t].name, l, tbl[t].dexp[l]);
      check_model({tbl[t].name, "_all"});
    end

    // Enable hold then re-enable.
    in_v    = '0;
    in_v[1] = 16'h1234;
    en      = 1'b1;
    tick();
    check_lane("en_load", 1, 16'h1234);
    en      = 1'b0;
    in_v[1] = 16'h4321;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_lane("en_hold", 1, 16'h1234);
    end
    en = 1'b1;
    tick();
    check_lane("en_reload", 1, 16'h4321);

    // Lane mapping across every lane.
    for (int i = 0; i < LN; i++) in_v[i] = DW'(i + 1);
    tick();
    begin
      int bad;
      bad = -1;
      for (int i = LN - 1; i >= 0; i--) if (out_v[i] !== DW'(i + 1)) bad = i;
      checks++;
      if (bad >= 0) begin
        errors++;
        $display("FAIL lane_map: lane %0d got %h expected %h", bad, out_v[bad], DW'(bad + 1));
      end
    end

    // Asynchronous reset between edges clears without a clock.
    #2;
    reset = 1'b1;
    #1;
    model_clear();
    check_lane("async_reset_lane5", 5, 16'h0000);
    check_model("async_reset_all");
    @(posedge clk);
    #1;
    reset = 1'b0;
    en    = 1'b0;
    for (int i = 0; i < LN; i++) in_v[i] = 16'h0055;
    tick();
    check_model("no_replay_after_reset");
    en = 1'b1;
    tick();
    check_lane("first_load_after_reset", 7, 16'h0055);

    // Randomized traffic with occasional reset pulses.
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < LN; i++) in_v[i] = pick_value();
      en    = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 39) == 0);
      tick();
      check_model("random");
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule : tb_relu
`default_nettype wire

// File: doc/relu.md
# relu

Vectorised, registered rectified-linear activation stage. Applies ReLU (max(x, 0)) independently to each of LENGTH signed two's-complement lanes of DATA_WIDTH bits and registers the result. Sits in the TPU datapath after the accumulator/systolic array output, before the next-layer buffer.

## Interface

Parameters:
- DATA_WIDTH, 16, bit width of each lane, signed two's complement.
- LENGTH, 64, number of parallel lanes.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all output registers.
- en  input  1  update enable; when high, output registers load new results on the clock edge.
- In  input  [LENGTH-1:0][DATA_WIDTH-1:0]  packed lane vector; In[i] is lane i.
- Out  output  [0:LENGTH-1][DATA_WIDTH-1:0]  packed lane vector, ascending outer range; Out[i] is the result for In[i].

## Operation

- Per lane i, independently: if In[i][DATA_WIDTH-1] == 1 (negative), result is 0; otherwise result is In[i] unchanged.
- Zero input gives zero output; most positive value (0x7FFF for 16 bits) passes unchanged; most negative (0x8000) gives 0.
- No saturation, scaling or width change; output width equals input width.
- Lanes are fully independent; no cross-lane logic.
- Lane mapping is by index, not by bit position: Out[i] corresponds to In[i] even though the outer ranges of In and Out are declared in opposite directions. Use index-based assignment, not whole-vector assignment.
- en low: Out holds its previous value regardless of In.
- No internal state besides the output registers; no FSM.

## Timing

- reset asserted (any time, asynchronous): all Out lanes become 0 immediately and stay 0 while reset is high, regardless of en or clk.
- reset deasserted: first load occurs on the first rising clk edge with en == 1.
- Latency: 1 cycle. Out reflects ReLU(In) sampled at the rising edge where en == 1 and is stable until the next enabled edge.
- en and In are sampled only at the rising edge; changes between edges have no effect on Out.
- reset and en high simultaneously: reset wins, Out == 0.
- Reset mid-operation discards the held value; nothing is replayed after release.

## Structure

- Shared package relu_pkg: default DATA_WIDTH/LENGTH constants and a lane typedef (logic signed [DATA_WIDTH-1:0]) for use by neighbouring datapath blocks.
- One natural sub-module: relu_lane (combinational, one lane: sign-bit test and mux to zero). relu instantiates LENGTH copies with a generate loop and holds the LENGTH×DATA_WIDTH output register bank with async reset and enable.

## Test plan

- Reset: hold reset high with en=1 and arbitrary In -> all Out lanes 0x0000; assert reset asynchronously mid-cycle after loading data -> Out clears without waiting for a clock edge.
- Mixed signs: In[0..3] = 0x0000, 0x7FFF, 0x8000, 0xFFFF, en=1, one edge -> Out[0..3] = 0x0000, 0x7FFF, 0x0000, 0x0000.
- All positive: In[0..3] = 0x0001, 0x000A, 0x00FF, 0x7FFF -> Out[0..3] identical to In after one edge.
- All negative: In[0..3] = 0x8001, 0xFFFE, 0xFFFF, 0x8000 -> Out[0..3] all 0x0000.
- Enable hold: load In[1]=0x1234, then drop en and change In[1] to 0x4321 for several edges -> Out[1] stays 0x1234; raise en -> Out[1]=0x4321 after one edge.
- Lane mapping: distinct positive value per lane (In[i] = i+1) across all 64 lanes -> Out[i] = i+1 for every i, confirming index mapping despite opposite range directions.
